// File: rtl/pc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
// Shared definitions for the program-counter fetch block:
//   - fetch_state_e : jump-sequencer FSM state encoding
//   - COND_*        : 3-bit jump condition codes
//   - FLAG_*        : bit positions inside the {V,N,C,Z} flag vector
//   - TARGET_W      : width of the operand-assembled jump target
//   - cond_met()    : evaluates a condition code against the flags
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2,
    EVAL    = 2'd3
  } fetch_state_e;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_Z      = 3'd1;
  localparam logic [2:0] COND_NZ     = 3'd2;
  localparam logic [2:0] COND_C      = 3'd3;
  localparam logic [2:0] COND_NC     = 3'd4;
  localparam logic [2:0] COND_N      = 3'd5;
  localparam logic [2:0] COND_NN     = 3'd6;
  localparam logic [2:0] COND_V      = 3'd7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // Target is always assembled from two operand bytes.
  localparam int TARGET_W = 16;

  function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] flags);
    logic met;
    met = 1'b0;
    case (cond)
      COND_ALWAYS: met = 1'b1;
      COND_Z:      met = flags[FLAG_Z];
      COND_NZ:     met = ~flags[FLAG_Z];
      COND_C:      met = flags[FLAG_C];
      COND_NC:     met = ~flags[FLAG_C];
      COND_N:      met = flags[FLAG_N];
      COND_NN:     met = ~flags[FLAG_N];
      COND_V:      met = flags[FLAG_V];
      default:     met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// -----------------------------------------------------------------------------
// pc_ret_stack
// Small LIFO of return addresses used by pc_fetch when CALL_STACK_EN is set.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears the pointer)
//   push       : store push_data on top (ignored when full)
//   pop        : discard top entry (ignored when empty)
//   push_data  : address to push
//   top        : current top-of-stack entry (0 when empty)
//   full/empty : occupancy status
// -----------------------------------------------------------------------------
module pc_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int SP_W = $clog2(DEPTH + 1);

  logic [SP_W-1:0] sp_q, sp_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] wr_en;

  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);

  // The pointer names the next free slot, so a push writes entry sp_q.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && !full && (sp_q == SP_W'(gi));
  end

  always_comb begin
    sp_d = sp_q;
    if (push && !full) begin
      sp_d = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry contents need no reset: they are only visible below the pointer.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem_q[i] <= push_data;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) begin
        top = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Program counter with a byte-serial jump sequencer. A jump is started with
// jmp_start, collects a low and a high operand byte from the memory bus,
// evaluates its condition against the ALU flags for one cycle, and loads the
// PC when taken. pcc increments the PC in any state; a load wins over pcc.
// Optional feature macro: CALL_STACK_EN adds a return stack (pc_ret_stack)
// so call-jumps push the return address and ret pops it.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   pcc                 : PC increment enable
//   jmp_start           : start jump (accepted in IDLE only)
//   jmp_cond, call      : condition code and call marker, sampled with jmp_start
//   ret                 : return request (IDLE only, CALL_STACK_EN only)
//   data_in, data_valid : operand byte stream
//   flags               : {V,N,C,Z}
//   pc_addr             : current program address (registered)
//   busy                : sequencer not in IDLE
//   jmp_taken           : one-cycle pulse while PC shows a newly loaded address
//   stk_err             : sticky stack overflow/underflow
// -----------------------------------------------------------------------------
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcc,
  input  logic              jmp_start,
  input  logic [2:0]        jmp_cond,
  input  logic              call,
  input  logic              ret,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  input  logic [3:0]        flags,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              busy,
  output logic              jmp_taken,
  output logic              stk_err
);

  fetch_state_e          state_q, state_d;
  logic [2:0]            cond_q, cond_d;
  logic [TARGET_W-1:0]   target_q, target_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic                  jmp_taken_q, jmp_taken_d;
  logic [ADDR_W-1:0]     target_addr;
  logic                  load;
  logic [ADDR_W-1:0]     load_addr;

  // Fit the 16-bit operand target to the PC width.
  if (ADDR_W <= TARGET_W) begin : g_tgt_trunc
    assign target_addr = target_q[ADDR_W-1:0];
  end else begin : g_tgt_ext
    assign target_addr = {{(ADDR_W - TARGET_W){1'b0}}, target_q};
  end

`ifdef CALL_STACK_EN
  logic              call_q, call_d;
  logic              stk_err_q, stk_err_d;
  logic              stk_push, stk_pop;
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;

  pc_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_q),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );
`endif

  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    target_d    = target_q;
    load        = 1'b0;
    load_addr   = target_addr;
`ifdef CALL_STACK_EN
    call_d      = call_q;
    stk_err_d   = stk_err_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (jmp_start) begin
          cond_d  = jmp_cond;
`ifdef CALL_STACK_EN
          call_d  = call;
`endif
          state_d = WAIT_LO;
        end
`ifdef CALL_STACK_EN
        if (ret) begin
          if (stk_empty) begin
            stk_err_d = 1'b1;
          end else begin
            stk_pop   = 1'b1;
            load      = 1'b1;
            load_addr = stk_top;
          end
        end
`endif
      end
      WAIT_LO: begin
        if (data_valid) begin
          target_d[7:0] = data_in;
          state_d       = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (data_valid) begin
          target_d[15:8] = data_in;
          state_d        = EVAL;
        end
      end
      EVAL: begin
        state_d = IDLE;
        if (cond_met(cond_q, flags)) begin
          load      = 1'b1;
          load_addr = target_addr;
`ifdef CALL_STACK_EN
          // pc_q is the address after the operands, i.e. the return point.
          if (call_q) begin
            if (stk_full) begin
              stk_err_d = 1'b1;
            end else begin
              stk_push = 1'b1;
            end
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pc_d = load_addr;
    end else if (pcc) begin
      pc_d = pc_q + 1'b1;
    end else begin
      pc_d = pc_q;
    end
    jmp_taken_d = load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cond_q      <= '0;
      target_q    <= '0;
      pc_q        <= '0;
      jmp_taken_q <= 1'b0;
`ifdef CALL_STACK_EN
      call_q      <= 1'b0;
      stk_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cond_q      <= cond_d;
      target_q    <= target_d;
      pc_q        <= pc_d;
      jmp_taken_q <= jmp_taken_d;
`ifdef CALL_STACK_EN
      call_q      <= call_d;
      stk_err_q   <= stk_err_d;
`endif
    end
  end

  assign pc_addr   = pc_q;
  assign busy      = (state_q != IDLE);
  assign jmp_taken = jmp_taken_q;

`ifdef CALL_STACK_EN
  assign stk_err = stk_err_q;
`else
  // No stack in this build: call/ret have no effect.
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(STACK_DEPTH) ^ {30'd0, call, ret};
  assign stk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

  logic        clk;
  logic        rst;
  logic        pcc;
  logic        jmp_start;
  logic [2:0]  jmp_cond;
  logic        call;
  logic        ret;
  logic [7:0]  data_in;
  logic        data_valid;
  logic [3:0]  flags;
  logic [15:0] pc_addr;
  logic        busy;
  logic        jmp_taken;
  logic        stk_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] pc_m;
  logic [15:0] stk_m[$];

  pc_fetch #(.ADDR_W(16), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pcc        (pcc),
    .jmp_start  (jmp_start),
    .jmp_cond   (jmp_cond),
    .call       (call),
    .ret        (ret),
    .data_in    (data_in),
    .data_valid (data_valid),
    .flags      (flags),
    .pc_addr    (pc_addr),
    .busy       (busy),
    .jmp_taken  (jmp_taken),
    .stk_err    (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cond;
    logic [3:0]  flg;
    logic [7:0]  lo;
    logic [7:0]  hi;
    bit          p;
    bit          exp_taken;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Condition table straight from the flag definitions {V,N,C,Z}.
  function automatic bit model_cond(input logic [2:0] c, input logic [3:0] f);
    bit z, cy, n, v;
    bit tbl[8];
    z = f[0]; cy = f[1]; n = f[2]; v = f[3];
    tbl = '{1'b1, z, !z, cy, !cy, n, !n, v};
    return tbl[c];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One ordinary cycle: PC only moves by pcc, no load pulse.
  task automatic step(input bit p);
    pcc = p;
    tick();
    if (p) pc_m = pc_m + 16'd1;
    check("pc_step", pc_addr, pc_m);
    check("taken_low", jmp_taken, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; pcc = 0; jmp_start = 0; jmp_cond = 0; call = 0; ret = 0;
    data_in = 0; data_valid = 0; flags = 0;
    #3;
    check("rst_pc", pc_addr, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_taken", jmp_taken, 1'b0);
    check("rst_stkerr", stk_err, 1'b0);
    rst = 1'b0;
    pc_m = 16'h0000;
    stk_m.delete();
  endtask

  task automatic run_jump(input logic [2:0] c, input bit cl, input logic [3:0] f,
                          input logic [7:0] lo, input logic [7:0] hi, input bit p,
                          input int gap_lo, input int gap_hi, output bit seen);
    bit tk;
    flags = f; jmp_cond = c; call = cl; jmp_start = 1'b1;
    step(p);
    jmp_start = 1'b0; call = 1'b0;
    check("busy_start", busy, 1'b1);
    for (int i = 0; i < gap_lo; i++) step(p);
    data_valid = 1'b1; data_in = lo;
    step(p);
    data_valid = 1'b0; data_in = 8'h00;
    for (int i = 0; i < gap_hi; i++) begin
      step(p);
      check("busy_wait_hi", busy, 1'b1);
    end
    data_valid = 1'b1; data_in = hi;
    step(p);
    data_valid = 1'b0;
    check("busy_eval", busy, 1'b1);
    // EVAL cycle
    pcc = p;
    tick();
    tk = model_cond(c, f);
    if (tk) begin
      if (cl) begin
        if (stk_m.size() < 4) stk_m.push_back(pc_m);
      end
      pc_m = {hi, lo};
    end else if (p) begin
      pc_m = pc_m + 16'd1;
    end
    seen = jmp_taken;
    check("jmp_taken", jmp_taken, tk);
    check("pc_after_eval", pc_addr, pc_m);
    check("busy_idle", busy, 1'b0);
    pcc = 1'b0;
    $display("jump cond=%0d call=%0d flags=%b target=%02h%02h pcc=%0d taken=%0d pc=%04h",
             c, cl, f, hi, lo, p, jmp_taken, pc_addr);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{3'd0, 4'b0000, 8'h34, 8'h12, 1'b0, 1'b1, 16'h1234};
    vecs[1] = '{3'd1, 4'b0000, 8'h00, 8'h80, 1'b1, 1'b0, 16'h0004};
    vecs[2] = '{3'd1, 4'b0001, 8'h78, 8'h56, 1'b1, 1'b1, 16'h5678};
    vecs[3] = '{3'd2, 4'b0001, 8'h11, 8'h22, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{3'd3, 4'b0010, 8'hCD, 8'hAB, 1'b0, 1'b1, 16'hABCD};
    vecs[5] = '{3'd4, 4'b0010, 8'h11, 8'h22, 1'b1, 1'b0, 16'h0004};
    vecs[6] = '{3'd5, 4'b0100, 8'h01, 8'h00, 1'b1, 1'b1, 16'h0001};
    vecs[7] = '{3'd6, 4'b1011, 8'hFF, 8'hFF, 1'b1, 1'b1, 16'hFFFF};
    vecs[8] = '{3'd7, 4'b0111, 8'h11, 8'h22, 1'b1, 1'b0, 16'h0004};
    vecs[9] = '{3'd7, 4'b1000, 8'h10, 8'h20, 1'b0, 1'b1, 16'h2010};

    do_reset();

    // Count 5 then wrap from all-ones.
    for (int i = 0; i < 5; i++) step(1'b1);
    check("pc_count5", pc_addr, 16'h0005);
    $display("count pcc x5 pc=%04h", pc_addr);
    run_jump(3'd0, 1'b0, 4'b0000, 8'hFF, 8'hFF, 1'b0, 0, 0, seen);
    step(1'b1);
    check("pc_wrap", pc_addr, 16'h0000);
    $display("wrap pc=%04h", pc_addr);

    // Table vectors, each from a fresh reset.
    for (int k = 0; k < 10; k++) begin
      do_reset();
      run_jump(vecs[k].cond, 1'b0, vecs[k].flg, vecs[k].lo, vecs[k].hi, vecs[k].p, 0, 0, seen);
      check("vec_taken", seen, vecs[k].exp_taken);
      check("vec_pc", pc_addr, vecs[k].exp_pc);
    end

    // Data withheld 3 cycles in WAIT_HI, with a stray jmp_start that must be ignored.
    do_reset();
    flags = 4'b0000; jmp_cond = 3'd0; jmp_start = 1'b1;
    step(1'b0);
    jmp_start = 1'b0;
    data_valid = 1'b1; data_in = 8'h55;
    step(1'b0);
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      jmp_start = (i == 1); jmp_cond = 3'd1;
      step(1'b0);
      check("hold_busy", busy, 1'b1);
    end
    jmp_start = 1'b0;
    data_valid = 1'b1; data_in = 8'h44;
    step(1'b0);
    data_valid = 1'b0;
    tick();
    check("hold_taken", jmp_taken, 1'b1);
    check("hold_pc", pc_addr, 16'h4455);
    pc_m = 16'h4455;
    step(1'b0);
    $display("withheld-data jump pc=%04h", pc_addr);

    // Asynchronous reset while in WAIT_HI abandons the jump.
    pc_m = pc_addr;
    flags = 4'b0000; jmp_cond = 3'd0; jmp_start = 1'b1;
    step(1'b1);
    jmp_start = 1'b0;
    data_valid = 1'b1; data_in = 8'h21;
    step(1'b1);
    data_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_pc", pc_addr, 16'h0000);
    check("arst_busy", busy, 1'b0);
    #1 rst = 1'b0;
    pc_m = 16'h0000;
    data_valid = 1'b1; data_in = 8'h43;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check("arst_idle", busy, 1'b0);
    end
    data_valid = 1'b0;
    $display("reset mid-jump pc=%04h busy=%0d", pc_addr, busy);

    // Randomized jumps against the model.
    do_reset();
    for (int t = 0; t < 30; t++) begin
      int idle_n;
      idle_n = $urandom_range(0, 2);
      for (int i = 0; i < idle_n; i++) step(1'($urandom_range(0, 1)));
      run_jump(3'($urandom_range(0, 7)), 1'b0, 4'($urandom_range(0, 15)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2), seen);
    end

`ifdef CALL_STACK_EN
    // Call / return and stack error handling.
    do_reset();
    run_jump(3'd0, 1'b0, 4'b0000, 8'h03, 8'h01, 1'b0, 0, 0, seen);
    run_jump(3'd0, 1'b1, 4'b0000, 8'h00, 8'h20, 1'b0, 0, 0, seen);
    check("call_pc", pc_addr, 16'h2000);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    pc_m = stk_m.pop_back();
    check("ret_pc", pc_addr, 16'h0103);
    check("ret_taken", jmp_taken, 1'b1);
    check("ret_stkerr", stk_err, 1'b0);
    $display("ret pc=%04h", pc_addr);
    step(1'b0);
    for (int k = 0; k < 5; k++) begin
      run_jump(3'd0, 1'b1, 4'b0000, 8'(k), 8'h30, 1'b0, 0, 0, seen);
      check("push_stkerr", stk_err, (k == 4));
    end
    do_reset();
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("pop_empty_pc", pc_addr, 16'h0000);
    check("pop_empty_taken", jmp_taken, 1'b0);
    check("pop_empty_err", stk_err, 1'b1);
    $display("ret on empty pc=%04h stk_err=%0d", pc_addr, stk_err);
`else
    // Without the stack, call and ret have no effect.
    do_reset();
    run_jump(3'd0, 1'b1, 4'b0000, 8'h00, 8'h20, 1'b0, 0, 0, seen);
    ret = 1'b1;
    step(1'b0);
    ret = 1'b0;
    check("noret_pc", pc_addr, 16'h2000);
    check("noret_stkerr", stk_err, 1'b0);
    $display("ret ignored pc=%04h", pc_addr);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, program-address width.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (used only with CALL_STACK_EN).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 pcc  input  1  PC count enable from control unit; increments PC by 1.
REQ-006 jmp_start  input  1  one-cycle pulse beginning a jump sequence.
REQ-007 jmp_cond  input  3  condition code sampled with jmp_start.
REQ-008 call  input  1  sampled with jmp_start; marks jump as a call.
REQ-009 ret  input  1  one-cycle pulse requesting return.
REQ-010 data_in  input  8  operand byte from memory bus.
REQ-011 data_valid  input  1  data_in holds the next operand byte.
REQ-012 flags  input  4  ALU flags {V,N,C,Z}, bit 0 = Z.
REQ-013 pc_addr  output  ADDR_W  current program address.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 jmp_taken  output  1  one-cycle pulse when PC is loaded by jump or return.
REQ-016 stk_err  output  1  sticky stack overflow/underflow flag.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_LO, WAIT_HI, EVAL.
REQ-018 IDLE + jmp_start SHALL latch jmp_cond and call, then go to WAIT_LO; jmp_start outside IDLE SHALL be ignored.
REQ-019 WAIT_LO + data_valid SHALL capture data_in as target[7:0] and go to WAIT_HI; without data_valid, state holds.
REQ-020 WAIT_HI + data_valid SHALL capture data_in as target[15:8] and go to EVAL; target bits above ADDR_W are discarded, bits below are zero-filled.
REQ-021 EVAL SHALL last exactly one cycle and return to IDLE.
REQ-022 Conditions: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 V; evaluated on flags during EVAL.
REQ-023 Taken in EVAL: pc_addr <= target next edge; jmp_taken high for that one cycle.
REQ-024 Not taken: pc_addr unaffected by jump logic.
REQ-025 pcc SHALL increment pc_addr in every state, modulo 2^ADDR_W (wrap all-ones -> 0).
REQ-026 Simultaneous pcc and taken jump/return: load wins, no increment.
REQ-027 Jump-to-PC latency: 1 cycle after second data_valid edge enters EVAL, PC updated on the following edge.

Reset
REQ-028 rst SHALL force pc_addr=0, state=IDLE, busy=0, jmp_taken=0, stk_err=0, target=0, stack pointer=0, immediately and asynchronously.
REQ-029 rst mid-sequence SHALL abandon the jump; no partial target is applied after release.

Configuration
REQ-030 With CALL_STACK_EN defined: taken jump with call=1 SHALL push pc_addr (post-operand return address) before loading target.
REQ-031 With CALL_STACK_EN: ret in IDLE SHALL pop top entry into pc_addr with jmp_taken pulse; ret outside IDLE is ignored.
REQ-032 Push when full: jump still taken, push dropped, stk_err set. Pop when empty: pc_addr unchanged, no jmp_taken, stk_err set.
REQ-033 Without CALL_STACK_EN: no stack storage, call and ret ignored, stk_err tied 0.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding and the 3-bit condition-code constants.
REQ-035 Return stack SHALL be sub-module pc_ret_stack (push, pop, full, empty, top), instantiated only under CALL_STACK_EN.
REQ-036 pc_addr SHALL be driven directly from a register.

Verification
REQ-037 Reset, pcc high 5 cycles -> pc_addr 0x0005; at 0xFFFF pcc -> 0x0000.
REQ-038 jmp_start cond=0, bytes 0x34 then 0x12 -> jmp_taken one cycle, pc_addr=0x1234.
REQ-039 cond=1, flags Z=0, bytes 0x00 0x80 -> no jmp_taken, pc_addr only advances by pcc count.
REQ-040 data_valid withheld 3 cycles in WAIT_HI -> busy stays 1, state holds, then jump completes normally.
REQ-041 rst asserted in WAIT_HI -> pc_addr=0, busy=0; later data_valid causes no load.
REQ-042 CALL_STACK_EN: call at pc 0x0103 to 0x2000, then ret -> pc_addr 0x0103; five calls with depth 4 -> stk_err=1; ret on empty -> stk_err=1, pc unchanged.
